// File: rtl/cache_types_pkg.sv
// Shared sizing, types and helpers for the cache line to memory burst adapter.
package cache_types_pkg;

  localparam int S_OFFSET = 5;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = 4;
  localparam int LINE_W   = BEAT_W * BEATS;
  localparam int ADDR_W   = 32;
  localparam int CNT_W    = $clog2(BEATS);

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]  beat_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } adapter_state_e;

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << S_OFFSET) - 1);
  localparam beat_cnt_t         LAST_BEAT   = beat_cnt_t'(BEATS - 1);

  // Memory bursts always start at the first byte of the line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

endpackage

// File: rtl/cacheline_burst_adapter.sv
// Turns one 256-bit cache line read/write into a 4-beat x 64-bit memory burst,
// lowest word first, with a single outstanding request.
module cacheline_burst_adapter
  import cache_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  adapter_state_e state, state_next;
  beat_cnt_t      beat_cnt;
  line_t          line_buf;
  beat_t          wr_beat;
  logic           accept_rd, accept_wr, take_beat, last_beat;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign wr_beat   = line_buf[int'(beat_cnt)*BEAT_W +: BEAT_W];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Write wins when both requests arrive together; DONE ignores requests.
  always_comb begin
    state_next = state;
    accept_rd  = 1'b0;
    accept_wr  = 1'b0;
    take_beat  = 1'b0;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    burst_o    = '0;
    case (state)
      IDLE: begin
        if (write_i) begin
          accept_wr  = 1'b1;
          state_next = WR_BURST;
        end else if (read_i) begin
          accept_rd  = 1'b1;
          state_next = RD_BURST;
        end
      end
      RD_BURST: begin
        read_o = 1'b1;
        if (resp_i) begin
          take_beat = 1'b1;
          if (last_beat) state_next = DONE;
        end
      end
      WR_BURST: begin
        write_o = 1'b1;
        burst_o = wr_beat;
        if (resp_i) begin
          take_beat = 1'b1;
          if (last_beat) state_next = DONE;
        end
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      line_buf  <= '0;
      line_o    <= '0;
      address_o <= '0;
    end else begin
      if (accept_wr || accept_rd) address_o <= line_align(address_i);
      if (accept_wr) line_buf <= line_i;
      if (take_beat) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        if (state == RD_BURST) line_o[int'(beat_cnt)*BEAT_W +: BEAT_W] <= burst_i;
      end
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench: stimulus queues expected transactions, a negedge monitor acts as
// the burst memory and compares beats, line data and completions against them.
module tb_cacheline_burst_adapter;
  import cache_types_pkg::*;

  typedef struct {
    bit           is_wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;

  always #5 clk = ~clk;

  cacheline_burst_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  txn_t         exp_q[$];
  logic [63:0]  rd_beats[$];
  logic [63:0]  wr_beats[$];
  int           vectors       = 0;
  int           miscompares   = 0;
  int           rd_beat_total = 0;
  int           wait_cnt      = 0;
  int           patt_idx      = 0;
  int           mode          = 0;
  bit           stray_en      = 1'b0;
  logic         rst_at_edge   = 1'b0;
  logic [255:0] last_line     = '0;
  logic [6:0]   patt          = 7'b1101001;

  always @(posedge clk) rst_at_edge <= rst;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Memory model plus monitor: answers bursts and checks everything the DUT presents.
  always @(negedge clk) begin : monitor
    txn_t t;
    bit   go;
    if (rst_at_edge) begin
      check_output("reset_read_o", read_o, 0);
      check_output("reset_write_o", write_o, 0);
      check_output("reset_resp_o", resp_o, 0);
      check_output("reset_address_o", address_o, 0);
      check_output("reset_line_o", line_o, 0);
      check_output("reset_burst_o", burst_o, 0);
      exp_q.delete();
      rd_beats.delete();
      wr_beats.delete();
      last_line = '0;
      wait_cnt  = 0;
      patt_idx  = 0;
      resp_i    = 1'b0;
    end else begin
      if (resp_o) begin
        if (exp_q.size() == 0) begin
          report_fail("unexpected_resp", "resp_o high, required no completion pending");
        end else begin
          t = exp_q.pop_front();
          check_output("resp_address", address_o, t.addr);
          if (!t.is_wr) begin
            check_output("read_line", line_o, t.line);
            last_line = t.line;
          end
        end
        wait_cnt = 0;
      end else if (exp_q.size() != 0) begin
        wait_cnt++;
        if (wait_cnt > 120) begin
          report_fail("resp_timeout", "no resp_o within 120 cycles, required completion");
          void'(exp_q.pop_front());
          wait_cnt = 0;
        end
      end

      if (read_o || write_o) begin
        check_output("one_direction", read_o & write_o, 0);
        if (exp_q.size() != 0) begin
          check_output("burst_direction", write_o, exp_q[0].is_wr);
          check_output("burst_address", address_o, exp_q[0].addr);
        end else begin
          check_output("burst_without_request", {read_o, write_o}, 0);
        end
      end
      if (!read_o) check_output("line_hold", line_o, last_line);

      case (mode)
        1:       go = 1'b1;
        2:       go = patt[patt_idx];
        default: go = ($urandom_range(0, 2) != 0);
      endcase
      resp_i  = 1'b0;
      burst_i = {$urandom, $urandom};
      if (read_o && go) begin
        resp_i = 1'b1;
        rd_beat_total++;
        if (rd_beats.size() == 0) report_fail("extra_read_beat", "read beat requested, required none");
        else burst_i = rd_beats.pop_front();
      end else if (write_o && go) begin
        resp_i = 1'b1;
        if (wr_beats.size() == 0) report_fail("extra_write_beat", "write beat offered, required none");
        else check_output("write_beat", burst_o, wr_beats.pop_front());
      end else if (!read_o && !write_o && stray_en && $urandom_range(0, 3) == 0) begin
        resp_i = 1'b1;
      end
      if (read_o || write_o) patt_idx = (patt_idx + 1) % 7;
      else                   patt_idx = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: bursts start at the line-aligned address, beat i is word i of the line.
  task automatic apply_stimulus(input bit wr, input bit rd, input logic [31:0] addr,
                                input logic [255:0] line, input logic [3:0][63:0] beats);
    txn_t t;
    t.is_wr = wr;
    t.addr  = addr - (addr % 32);
    t.line  = '0;
    for (int i = 0; i < 4; i++) begin
      if (wr) begin
        wr_beats.push_back(line[64*i +: 64]);
      end else begin
        rd_beats.push_back(beats[i]);
        t.line[64*i +: 64] = beats[i];
      end
    end
    if (wr) t.line = line;
    exp_q.push_back(t);
    write_i   = wr;
    read_i    = rd;
    address_i = addr;
    line_i    = line;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      tick(1);
      n++;
      address_i = $urandom;
      line_i    = rand_line();
    end while (resp_o !== 1'b1 && n < 150);
    read_i  = 1'b0;
    write_i = 1'b0;
    if (resp_o !== 1'b1) begin
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
    end
    tick($urandom_range(2, 4));
  endtask

  initial begin
    logic [3:0][63:0] b;
    int snap;
    int n;
    bit wr;
    rst       = 1'b1;
    read_i    = 1'b1;
    write_i   = 1'b0;
    address_i = 32'h1000000C;
    line_i    = '0;
    tick(5);
    rst    = 1'b0;
    read_i = 1'b0;
    tick(2);

    mode = 1;
    b = {64'h88888888_99999999, 64'hAAAAAAAA_BBBBBBBB, 64'hCCCCCCCC_DDDDDDDD, 64'hEEEEEEEE_FFFFFFFF};
    apply_stimulus(1'b0, 1'b1, 32'h1000000C, '0, b);
    wait_done();

    apply_stimulus(1'b1, 1'b0, 32'hE0000000, {224'h0, 32'h00111100}, b);
    wait_done();

    mode = 2;
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    apply_stimulus(1'b0, 1'b1, $urandom, '0, b);
    wait_done();

    mode     = 0;
    stray_en = 1'b1;
    apply_stimulus(1'b1, 1'b1, $urandom, rand_line(), b);
    wait_done();

    mode = 1;
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    snap = rd_beat_total;
    apply_stimulus(1'b0, 1'b1, $urandom, '0, b);
    n = 0;
    while (rd_beat_total - snap < 2 && n < 50) begin
      tick(1);
      n++;
    end
    rst    = 1'b1;
    read_i = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
    apply_stimulus(1'b0, 1'b1, $urandom, '0, b);
    wait_done();

    for (int k = 0; k < 40; k++) begin
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      wr   = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
      apply_stimulus(wr, !wr || ($urandom_range(0, 7) == 0), $urandom, rand_line(), b);
      wait_done();
    end

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
